ui_text_renderer: RTL and testbench
===================================

// Module: ui_text_renderer
// PURPOSE
//  Downstream of the UI runtime's character-object reader: accepts one glyph record per handshake
//  (screen position + font index) for the active UI entry and stores it in a small slot buffer.
//  Per scanned pixel (x,y), finds the covering glyph, fetches its font row from an external
//  synchronous font ROM and outputs text_signal, ORed with ui_signal at the pixel mux.
// PARAMETERS
//  MAX_CHARS        16  glyph slots held per UI entry
//  GLYPH_W          8   glyph width in font pixels (font_row width)
//  GLYPH_H          8   glyph height in font rows (power of two)
//  SCALE_SHIFT      1   on-screen magnification = 1<<SCALE_SHIFT in both axes
//  FONT_ADDR_WIDTH  11  font ROM address = {char_index[7:0], row[log2(GLYPH_H)-1:0]}
// PORTS
//  clk         in   1   calculation clock
//  reset       in   1   synchronous, active-high
//  clear       in   1   new UI entry: empty the slot buffer (1-cycle pulse)
//  char_valid  in   1   glyph record offered
//  char_ready  out  1   buffer can accept a record this cycle
//  char_pos_x  in   10  glyph top-left x (screen pixels)
//  char_pos_y  in   10  glyph top-left y
//  char_index  in   8   font index; 0 = blank (occupies slot, never lit)
//  x, y        in   10  current scan pixel
//  font_addr   out  FONT_ADDR_WIDTH  registered font ROM address
//  font_row    in   GLYPH_W  ROM data, valid one cycle after font_addr; MSB = leftmost pixel
//  text_signal out  1   pixel is lit glyph foreground
//  char_count  out  log2(MAX_CHARS)+1  records currently stored
//  overflow    out  1   sticky: record offered while buffer full
// BEHAVIOUR
//  Reset: char_count=0, overflow=0, font_addr=0, text_signal=0, pipeline hit flags=0;
//   char_ready=0 in reset cycle.
//  char_ready = !reset && !clear && (char_count < MAX_CHARS) (combinational).
//  Write: char_valid && char_ready at edge -> slot[char_count] <= record; char_count += 1.
//  Full: char_valid while char_count==MAX_CHARS -> record dropped, overflow <= 1.
//  clear has priority over a same-cycle write: char_count <= 0, overflow <= 0, record dropped.
//  Slots beyond char_count are ignored (no stale hits after clear).
//  Hit test, 11-bit unsigned, no wrap: px <= x < px + (GLYPH_W<<SCALE_SHIFT),
//   py <= y < py + (GLYPH_H<<SCALE_SHIFT). Glyphs past x=639/y=479 are clipped by scan range.
//  Overlap: lowest slot number wins.
//  col = (x-px)>>SCALE_SHIFT, row = (y-py)>>SCALE_SHIFT.
//  Pipeline (latency 2 edges):
//   E0: register hit, col, blank=(index==0); font_addr <= {index,row} (held if no hit).
//   E1: ROM returns font_row; delay hit/col/blank one stage.
//   E2: text_signal <= hit && !blank && font_row[GLYPH_W-1-col].
//  Buffer writes do not stall the pipeline. A pixel sampled in the same edge as a write
//   sees the pre-write buffer.
//  clear mid-pipeline: in-flight pixels complete with their latched hit; new pixels see empty buffer.
//  reset mid-operation: pipeline flushed, text_signal 0 next edge, buffer emptied.
// TESTING
//  1 reset, then drive 16 records with char_valid held -> char_ready high 16 cycles,
//    char_count=16, char_ready low after.
//  2 17th record while full -> dropped, overflow=1; clear -> char_count=0, overflow=0,
//    char_ready=1 next cycle.
//  3 one glyph (100,200,idx 65), SCALE_SHIFT=1, ROM row 0=8'b1000_0001; scan y=200,
//    x=100..115 -> text_signal=1 at x=100,101,114,115 only, 2 edges after each x.
//  4 glyphs in slot0 and slot1 both at (50,50), different rows -> output follows slot0 only.
//  5 clear and char_valid in same cycle -> char_count=0, record not stored, no hits afterwards.
//  6 glyph at (630,470), idx 0 -> font_addr updates but text_signal stays 0; x=639 no wrap
//    hit on glyph at x=0.

Source files
------------

// File: rtl/ui_text_renderer.sv
// ui_text_renderer: holds up to MAX_CHARS glyph records per UI entry and renders lit text pixels via a font ROM.
// Latency: text_signal for the pixel sampled at edge E0 is valid after edge E2 (2 edges later).
// Backpressure: char_ready low in reset, during clear or when full; records offered while full are dropped and set overflow.
module ui_text_renderer #(
   parameter int MAX_CHARS       = 16,
   parameter int GLYPH_W         = 8,
   parameter int GLYPH_H         = 8,
   parameter int SCALE_SHIFT     = 1,
   parameter int FONT_ADDR_WIDTH = 11
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         char_valid,
   output logic                         char_ready,
   input  logic [9:0]                   char_pos_x,
   input  logic [9:0]                   char_pos_y,
   input  logic [7:0]                   char_index,
   input  logic [9:0]                   x,
   input  logic [9:0]                   y,
   output logic [FONT_ADDR_WIDTH-1:0]   font_addr,
   input  logic [GLYPH_W-1:0]           font_row,
   output logic                         text_signal,
   output logic [$clog2(MAX_CHARS):0]   char_count,
   output logic                         overflow
);

   localparam int SEL_W = $clog2(MAX_CHARS);
   localparam int ROW_W = $clog2(GLYPH_H);
   localparam int COL_W = $clog2(GLYPH_W);
   // On-screen glyph footprint, evaluated in 11 bits so a glyph near x=1023 does not wrap to x=0
   localparam logic [10:0] SPAN_X = 11'(GLYPH_W << SCALE_SHIFT);
   localparam logic [10:0] SPAN_Y = 11'(GLYPH_H << SCALE_SHIFT);

   // Slot buffer
   logic [9:0]        r_pos_x [MAX_CHARS];
   logic [9:0]        r_pos_y [MAX_CHARS];
   logic [7:0]        r_idx   [MAX_CHARS];
   logic [SEL_W:0]    r_count;
   logic              r_overflow;
   logic              w_wr;

   // Per-slot hit test and priority select
   logic [10:0]          w_dx [MAX_CHARS];
   logic [10:0]          w_dy [MAX_CHARS];
   logic [MAX_CHARS-1:0] w_slot_hit;
   logic                 w_hit;
   logic [SEL_W-1:0]     w_sel;
   logic [COL_W-1:0]     w_col;
   logic [ROW_W-1:0]     w_row;
   logic [7:0]           w_idx;
   logic [FONT_ADDR_WIDTH-1:0] w_addr;

   // Pipeline stages
   logic                       r_hit0, r_hit1;
   logic                       r_blank0, r_blank1;
   logic [COL_W-1:0]           r_col0, r_col1;
   logic [FONT_ADDR_WIDTH-1:0] r_font_addr;
   logic                       r_text;
   logic [GLYPH_W-1:0]         w_col_mask;
   logic                       w_font_bit;

   assign char_ready = !reset && !clear && (r_count < (SEL_W+1)'(MAX_CHARS));
   assign w_wr       = char_valid && char_ready;

   // Record count and sticky overflow; clear beats a same-cycle write
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_wr) begin
         r_count    <= r_count + 1'b1;
      end else if (char_valid) begin
         // Not ready outside reset/clear means the buffer is full
         r_overflow <= 1'b1;
      end
   end

   // Slot storage; slots at or beyond r_count are masked by the hit test, so no reset is needed
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_pos_x[r_count[SEL_W-1:0]] <= char_pos_x;
         r_pos_y[r_count[SEL_W-1:0]] <= char_pos_y;
         r_idx[r_count[SEL_W-1:0]]   <= char_index;
      end
   end

   // Per-slot coverage of the current scan pixel
   always_comb begin
      for (int i = 0; i < MAX_CHARS; i++) begin
         w_dx[i]       = {1'b0, x} - {1'b0, r_pos_x[i]};
         w_dy[i]       = {1'b0, y} - {1'b0, r_pos_y[i]};
         w_slot_hit[i] = ((SEL_W+1)'(i) < r_count)
                      && ({1'b0, x} >= {1'b0, r_pos_x[i]})
                      && ({1'b0, x} <  ({1'b0, r_pos_x[i]} + SPAN_X))
                      && ({1'b0, y} >= {1'b0, r_pos_y[i]})
                      && ({1'b0, y} <  ({1'b0, r_pos_y[i]} + SPAN_Y));
      end
   end

   // Lowest-numbered covering slot wins: scan downward so the last match is the lowest
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      for (int i = MAX_CHARS - 1; i >= 0; i--) begin
         if (w_slot_hit[i]) begin
            w_hit = 1'b1;
            w_sel = SEL_W'(i);
         end
      end
   end

   assign w_col  = COL_W'(w_dx[w_sel] >> SCALE_SHIFT);
   assign w_row  = ROW_W'(w_dy[w_sel] >> SCALE_SHIFT);
   assign w_idx  = r_idx[w_sel];
   assign w_addr = FONT_ADDR_WIDTH'({w_idx, w_row});

   // Column select into the ROM row; MSB is the leftmost pixel
   assign w_col_mask = {1'b1, {(GLYPH_W-1){1'b0}}} >> r_col1;
   assign w_font_bit = |(font_row & w_col_mask);

   // Render pipeline: E0 latch hit/address, E1 wait for ROM, E2 produce pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit0      <= 1'b0;
         r_hit1      <= 1'b0;
         r_blank0    <= 1'b0;
         r_blank1    <= 1'b0;
         r_col0      <= '0;
         r_col1      <= '0;
         r_font_addr <= '0;
         r_text      <= 1'b0;
      end else begin
         r_hit0   <= w_hit;
         r_col0   <= w_col;
         r_blank0 <= (w_idx == 8'd0);
         if (w_hit) begin
            r_font_addr <= w_addr;
         end
         r_hit1   <= r_hit0;
         r_col1   <= r_col0;
         r_blank1 <= r_blank0;
         r_text   <= r_hit1 && !r_blank1 && w_font_bit;
      end
   end

   assign font_addr   = r_font_addr;
   assign text_signal = r_text;
   assign char_count  = r_count;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_ui_text_renderer.sv
// tb_ui_text_renderer: directed bench for ui_text_renderer with a behavioural synchronous font ROM.
// Latency: pixel results are compared two edges after the pixel is sampled.
// Backpressure: records are offered with char_valid held and char_ready observed each cycle.
module tb_ui_text_renderer;

   logic        clk = 1'b0;
   logic        reset, clear, char_valid;
   logic        char_ready;
   logic [9:0]  char_pos_x, char_pos_y, x, y;
   logic [7:0]  char_index;
   logic [10:0] font_addr;
   logic [7:0]  font_row;
   logic        text_signal;
   logic [4:0]  char_count;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       exp;
   } vec_t;

   vec_t vq[$];

   ui_text_renderer dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .char_pos_x  (char_pos_x),
      .char_pos_y  (char_pos_y),
      .char_index  (char_index),
      .x           (x),
      .y           (y),
      .font_addr   (font_addr),
      .font_row    (font_row),
      .text_signal (text_signal),
      .char_count  (char_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Font ROM contents: idx 0 all-ones (blank must still stay dark), 65 and 66 distinct rows
   function automatic logic [7:0] rom(input logic [10:0] a);
      logic [7:0] ix;
      logic [2:0] r;
      ix = a[10:3];
      r  = a[2:0];
      if (ix == 8'd0) return 8'hFF;
      if (ix == 8'd65) begin
         if (r == 3'd0) return 8'b1000_0001;
         if (r == 3'd1) return 8'b1111_0000;
         return 8'b0001_1000;
      end
      if (ix == 8'd66) begin
         if (r == 3'd0) return 8'b0111_1110;
         return 8'hFF;
      end
      return 8'h00;
   endfunction

   // Synchronous ROM: data one cycle after the address
   always @(posedge clk) font_row <= rom(font_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [9:0] px, input logic [9:0] py, input logic [7:0] idx);
      char_valid = 1'b1;
      char_pos_x = px;
      char_pos_y = py;
      char_index = idx;
      tick();
      char_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic add(input logic [9:0] vx, input logic [9:0] vy, input logic e);
      vec_t v;
      v.x = vx;
      v.y = vy;
      v.exp = e;
      vq.push_back(v);
   endtask

   // Stream the queued pixels back-to-back; each result is visible two edges after its sample edge
   task automatic run_scan(input string name);
      int n;
      n = vq.size();
      for (int k = 0; k < n + 2; k++) begin
         if (k < n) begin
            x = vq[k].x;
            y = vq[k].y;
         end else begin
            x = 10'd0;
            y = 10'd0;
         end
         tick();
         if (k >= 2)
            check($sformatf("%s x=%0d y=%0d", name, vq[k-2].x, vq[k-2].y),
                  32'(text_signal), 32'(vq[k-2].exp));
      end
      vq.delete();
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; char_valid = 1'b0;
      char_pos_x = '0; char_pos_y = '0; char_index = '0;
      x = '0; y = '0;

      // Reset state
      tick();
      tick();
      check("rst_ready", 32'(char_ready), 0);
      check("rst_count", 32'(char_count), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_font_addr", 32'(font_addr), 0);
      check("rst_text", 32'(text_signal), 0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(char_ready), 1);

      // Test 1: fill all 16 slots with char_valid held
      char_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         char_pos_x = 10'(i * 20);
         char_pos_y = 10'd300;
         char_index = 8'd65;
         #1;
         check($sformatf("t1_ready_%0d", i), 32'(char_ready), 1);
         tick();
      end
      check("t1_count_full", 32'(char_count), 16);
      check("t1_ready_full", 32'(char_ready), 0);
      check("t1_overflow_clean", 32'(overflow), 0);

      // Test 2: 17th record dropped, then clear
      char_pos_x = 10'd999; char_pos_y = 10'd999; char_index = 8'd66;
      tick();
      char_valid = 1'b0;
      check("t2_overflow", 32'(overflow), 1);
      check("t2_count_held", 32'(char_count), 16);
      clear = 1'b1;
      #1;
      check("t2_ready_in_clear", 32'(char_ready), 0);
      tick();
      clear = 1'b0;
      #1;
      check("t2_count_clr", 32'(char_count), 0);
      check("t2_overflow_clr", 32'(overflow), 0);
      check("t2_ready_after", 32'(char_ready), 1);
      add(10'd0, 10'd300, 1'b0);
      add(10'd1, 10'd300, 1'b0);
      run_scan("t2_stale");

      // Test 3: single glyph at (100,200), row 0 = 1000_0001 magnified x2
      push(10'd100, 10'd200, 8'd65);
      for (int i = 99; i <= 116; i++)
         add(10'(i), 10'd200, (i == 100 || i == 101 || i == 114 || i == 115));
      run_scan("t3_row0");
      add(10'd100, 10'd199, 1'b0);
      add(10'd106, 10'd215, 1'b1);
      add(10'd104, 10'd215, 1'b0);
      add(10'd106, 10'd216, 1'b0);
      add(10'd100, 10'd202, 1'b1);
      add(10'd108, 10'd202, 1'b0);
      run_scan("t3_rows");
      check("t3_font_addr", 32'(font_addr), 65 * 8 + 1);

      // Test 4: two glyphs overlapping at (50,50); slot0 (idx 65) must win
      pulse_clear();
      push(10'd50, 10'd50, 8'd65);
      push(10'd50, 10'd50, 8'd66);
      check("t4_count", 32'(char_count), 2);
      for (int i = 50; i <= 65; i++)
         add(10'(i), 10'd50, (i == 50 || i == 51 || i == 64 || i == 65));
      run_scan("t4_overlap");

      // Test 5: clear and char_valid in the same cycle
      clear = 1'b1;
      char_valid = 1'b1;
      char_pos_x = 10'd300; char_pos_y = 10'd300; char_index = 8'd65;
      tick();
      clear = 1'b0;
      char_valid = 1'b0;
      check("t5_count", 32'(char_count), 0);
      add(10'd300, 10'd300, 1'b0);
      add(10'd301, 10'd301, 1'b0);
      add(10'd50,  10'd50,  1'b0);
      run_scan("t5_no_hit");

      // Test 6: blank glyph near the edge, then a lit glyph straddling x=1023
      push(10'd630, 10'd470, 8'd0);
      for (int i = 630; i <= 639; i++)
         add(10'(i), 10'd475, 1'b0);
      run_scan("t6_blank");
      check("t6_font_addr_blank", 32'(font_addr), 2);
      add(10'd0, 10'd475, 1'b0);
      run_scan("t6_x0");
      check("t6_font_addr_held", 32'(font_addr), 2);
      push(10'd1016, 10'd470, 8'd65);
      add(10'd1016, 10'd470, 1'b1);
      add(10'd1017, 10'd470, 1'b1);
      add(10'd1023, 10'd470, 1'b0);
      add(10'd0,    10'd470, 1'b0);
      add(10'd7,    10'd470, 1'b0);
      run_scan("t6_nowrap");

      // Pixel sampled on the same edge as a write sees the pre-write buffer
      pulse_clear();
      char_valid = 1'b1;
      char_pos_x = 10'd200; char_pos_y = 10'd100; char_index = 8'd65;
      x = 10'd200; y = 10'd100;
      tick();
      char_valid = 1'b0;
      tick();
      tick();
      check("wr_same_edge_pre", 32'(text_signal), 0);
      tick();
      check("wr_same_edge_post", 32'(text_signal), 1);

      // Reset with a lit pixel in flight
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_text", 32'(text_signal), 0);
      check("mid_rst_count", 32'(char_count), 0);
      check("mid_rst_font_addr", 32'(font_addr), 0);
      reset = 1'b0;
      add(10'd200, 10'd100, 1'b0);
      run_scan("mid_rst_empty");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
